// File: rtl/zoom_out.sv
// Streaming raster downscaler: reduces a WIDTH_IN x HEIGHT_IN 8-bit image by 2^k
// using either top-left decimation or 2^k x 2^k block averaging.
module zoom_out #(
    parameter int   WIDTH_IN  = 160,
    parameter int   HEIGHT_IN = 120,
    localparam int  XW        = $clog2(WIDTH_IN),
    localparam int  YW        = $clog2(HEIGHT_IN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flow_enabled,
    input  logic          algorithm_select,
    input  logic [1:0]    k,
    input  logic          sof,
    input  logic          in_valid,
    input  logic [7:0]    pix_in,
    output logic [7:0]    pix_out,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out,
    output logic          out_valid,
    output logic          frame_done
);
    localparam int NCOL = WIDTH_IN / 2;
    localparam int CIW  = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH_IN - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT_IN - 1);

    typedef enum logic {S_IDLE, S_ACTIVE} state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] xi_q, xi_d;
    logic [YW-1:0] yi_q, yi_d;
    logic [1:0]    k_q, k_d;
    logic          alg_q, alg_d;
    logic [10:0]   h_acc_q, h_acc_d;
    logic [13:0]   col_acc_q [NCOL];
    logic [13:0]   col_acc_d [NCOL];
    logic [7:0]    pix_out_q, pix_out_d;
    logic [XW-1:0] x_out_q, x_out_d;
    logic [YW-1:0] y_out_q, y_out_d;
    logic          out_valid_q, out_valid_d;
    logic          frame_done_q, frame_done_d;

    logic          take;
    logic [1:0]    k_eff;
    logic          alg_eff;
    logic [XW-1:0] x_cur;
    logic [YW-1:0] y_cur;
    logic [31:0]   f_m1, bx, by, lx, ly;
    logic          in_region;
    logic [CIW-1:0] col_idx;
    logic [10:0]   h_sum;
    logic [13:0]   v_sum;

    // A sof beat is pixel (0,0) of a new frame and uses the live k/algorithm inputs.
    always_comb begin
        take      = flow_enabled & in_valid & (sof | (state_q == S_ACTIVE));
        k_eff     = sof ? k : k_q;
        alg_eff   = sof ? algorithm_select : alg_q;
        x_cur     = sof ? '0 : xi_q;
        y_cur     = sof ? '0 : yi_q;
        f_m1      = (32'd1 << k_eff) - 32'd1;
        bx        = 32'(x_cur) >> k_eff;
        by        = 32'(y_cur) >> k_eff;
        lx        = 32'(x_cur) & f_m1;
        ly        = 32'(y_cur) & f_m1;
        in_region = (bx < 32'(WIDTH_IN >> k_eff)) && (by < 32'(HEIGHT_IN >> k_eff));
        col_idx   = (bx < 32'(NCOL)) ? CIW'(bx) : '0;
        h_sum     = ((lx == 32'd0) ? 11'd0 : h_acc_q) + {3'b000, pix_in};
        v_sum     = ((ly == 32'd0) ? 14'd0 : col_acc_q[col_idx]) + {3'b000, h_sum};
    end

    // NOTE: every combinational output is given a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        xi_d         = xi_q;
        yi_d         = yi_q;
        k_d          = k_q;
        alg_d        = alg_q;
        h_acc_d      = h_acc_q;
        col_acc_d    = col_acc_q;
        pix_out_d    = pix_out_q;
        x_out_d      = x_out_q;
        y_out_d      = y_out_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        if (take) begin
            k_d     = k_eff;
            alg_d   = alg_eff;
            h_acc_d = h_sum;

            // Rows with ly = 0 overwrite col_acc, so a resync needs no explicit clear.
            if (alg_eff && (k_eff != 2'd0) && (lx == f_m1) && in_region)
                col_acc_d[col_idx] = v_sum;

            if (in_region) begin
                if ((!alg_eff || (k_eff == 2'd0)) && (lx == 32'd0) && (ly == 32'd0)) begin
                    out_valid_d = 1'b1;
                    pix_out_d   = pix_in;
                    x_out_d     = XW'(bx);
                    y_out_d     = YW'(by);
                end else if (alg_eff && (k_eff != 2'd0) && (lx == f_m1) && (ly == f_m1)) begin
                    out_valid_d = 1'b1;
                    pix_out_d   = 8'(v_sum >> {k_eff, 1'b0});
                    x_out_d     = XW'(bx);
                    y_out_d     = YW'(by);
                end
            end

            state_d = S_ACTIVE;
            if ((x_cur == X_LAST) && (y_cur == Y_LAST)) begin
                xi_d         = '0;
                yi_d         = '0;
                state_d      = S_IDLE;
                frame_done_d = 1'b1;
            end else if (x_cur == X_LAST) begin
                xi_d = '0;
                yi_d = y_cur + YW'(1);
            end else begin
                xi_d = x_cur + XW'(1);
                yi_d = y_cur;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            xi_q         <= '0;
            yi_q         <= '0;
            k_q          <= '0;
            alg_q        <= 1'b0;
            h_acc_q      <= '0;
            pix_out_q    <= '0;
            x_out_q      <= '0;
            y_out_q      <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            // NOTE: col_acc is a small flop array, so it is reset like any other state.
            for (int i = 0; i < NCOL; i++) col_acc_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            xi_q         <= xi_d;
            yi_q         <= yi_d;
            k_q          <= k_d;
            alg_q        <= alg_d;
            h_acc_q      <= h_acc_d;
            pix_out_q    <= pix_out_d;
            x_out_q      <= x_out_d;
            y_out_q      <= y_out_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            col_acc_q    <= col_acc_d;
        end
    end

    assign pix_out    = pix_out_q;
    assign x_out      = x_out_q;
    assign y_out      = y_out_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_zoom_out.sv
// Self-checking bench for zoom_out: a block-level reference model feeds a scoreboard,
// driven by a vector table plus resync, stall and reset sequences.
module tb_zoom_out;
    logic       clk = 1'b0;
    logic       reset, flow_enabled, algorithm_select, sof, in_valid;
    logic [1:0] k;
    logic [7:0] pix_in;

    logic [7:0] a_pix, b_pix;
    logic [2:0] a_x;
    logic [1:0] a_y;
    logic [3:0] b_x;
    logic [2:0] b_y;
    logic       a_ov, a_fd, b_ov, b_fd;

    zoom_out #(.WIDTH_IN(8), .HEIGHT_IN(4)) dut_a (
        .clk(clk), .reset(reset), .flow_enabled(flow_enabled),
        .algorithm_select(algorithm_select), .k(k), .sof(sof), .in_valid(in_valid),
        .pix_in(pix_in), .pix_out(a_pix), .x_out(a_x), .y_out(a_y),
        .out_valid(a_ov), .frame_done(a_fd));

    zoom_out #(.WIDTH_IN(10), .HEIGHT_IN(6)) dut_b (
        .clk(clk), .reset(reset), .flow_enabled(flow_enabled),
        .algorithm_select(algorithm_select), .k(k), .sof(sof), .in_valid(in_valid),
        .pix_in(pix_in), .pix_out(b_pix), .x_out(b_x), .y_out(b_y),
        .out_valid(b_ov), .frame_done(b_fd));

    always #5 clk = ~clk;

    typedef struct {
        int tag;
        bit ov;
        bit fd;
        int pix;
        int x;
        int y;
    } ev_t;

    typedef struct {
        int sel;
        int k;
        bit alg;
        int pat;
        int stall_at;
        int exp_count;
        int sx;
        int sy;
        int spix;
    } vec_t;

    ev_t  sb[$];
    ev_t  e_m;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   sel = 1'b0;
    int   out_count, fd_count, spot_pix, spot_x, spot_y;

    int   m_w = 8, m_h = 4;
    bit   m_active = 1'b0;
    int   m_x, m_y, m_k;
    bit   m_alg;
    int   img [16][16];

    logic        s_ov, s_fd;
    logic [7:0]  s_pix;
    logic [31:0] s_x, s_y;
    assign s_ov  = sel ? b_ov : a_ov;
    assign s_fd  = sel ? b_fd : a_fd;
    assign s_pix = sel ? b_pix : a_pix;
    assign s_x   = sel ? 32'(b_x) : 32'(a_x);
    assign s_y   = sel ? 32'(b_y) : 32'(a_y);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            while (sb.size() > 0 && sb[0].tag < cyc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL missed_strobe: nothing seen, expected strobe at cycle %0d", sb[0].tag);
                void'(sb.pop_front());
            end
            if (s_ov || s_fd) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: ov=%0d fd=%0d at cycle %0d, expected none",
                             s_ov, s_fd, cyc);
                end else begin
                    e_m = sb.pop_front();
                    check("strobe_cycle", cyc, e_m.tag);
                    check("out_valid", 32'(s_ov), 32'(e_m.ov));
                    check("frame_done", 32'(s_fd), 32'(e_m.fd));
                    if (e_m.ov) begin
                        check("pix_out", 32'(s_pix), e_m.pix);
                        check("x_out", s_x, e_m.x);
                        check("y_out", s_y, e_m.y);
                    end
                end
                if (s_ov) begin
                    out_count++;
                    if (s_x == 32'(spot_x) && s_y == 32'(spot_y)) spot_pix = 32'(s_pix);
                end
                if (s_fd) fd_count++;
            end
        end
    end

    // Reference model: stores the frame and averages whole blocks when they complete.
    task automatic model_beat(input bit s, input int p, input int kk, input bit al);
        ev_t e;
        int f, bx, by, lx, ly, sum;
        bit emit, last;
        if (s) begin
            m_active = 1'b1; m_x = 0; m_y = 0; m_k = kk; m_alg = al;
        end else if (!m_active) begin
            return;
        end
        img[m_y][m_x] = p;
        f  = 1 << m_k;
        bx = m_x / f; by = m_y / f; lx = m_x % f; ly = m_y % f;
        emit = 1'b0;
        e = '{default: 0};
        if (bx < m_w / f && by < m_h / f) begin
            if ((!m_alg || m_k == 0) && lx == 0 && ly == 0) begin
                emit = 1'b1; e.pix = p;
            end else if (m_alg && m_k > 0 && lx == f - 1 && ly == f - 1) begin
                sum = 0;
                for (int i = 0; i < f; i++)
                    for (int j = 0; j < f; j++) sum += img[by * f + i][bx * f + j];
                emit = 1'b1; e.pix = sum / (f * f);
            end
        end
        last  = (m_x == m_w - 1) && (m_y == m_h - 1);
        e.tag = cyc + 1; e.ov = emit; e.fd = last; e.x = bx; e.y = by;
        if (emit || last) sb.push_back(e);
        if (last) begin
            m_x = 0; m_y = 0; m_active = 1'b0;
        end else if (m_x == m_w - 1) begin
            m_x = 0; m_y++;
        end else begin
            m_x++;
        end
    endtask

    task automatic drive(input bit fe, input bit iv, input bit s, input int p,
                         input int kk, input bit al);
        @(posedge clk);
        #1;
        flow_enabled = fe; in_valid = iv; sof = s;
        pix_in = 8'(p); k = 2'(kk); algorithm_select = al;
        if (fe && iv) model_beat(s, p, kk, al);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    function automatic int pat_val(input int pat, input int x, input int y);
        if (pat == 0) return y * m_w + x;
        if (pat == 2 && x < 2 && y < 2) begin
            if (y == 0) return (x == 0) ? 10 : 20;
            return (x == 0) ? 30 : 41;
        end
        if (pat == 3) return 255;
        return 10 * y + x;
    endfunction

    // Non-sof beats carry random k/algorithm values, which must be ignored mid-frame.
    task automatic run_frame(input int kk, input bit al, input int pat,
                             input int stall_at, input int n_beats);
        int x, y;
        for (int idx = 0; idx < n_beats; idx++) begin
            x = idx % m_w; y = idx / m_w;
            if (idx == stall_at)
                for (int s = 0; s < 5; s++) drive(1'b0, 1'b1, 1'b0, 8'hAA, 3, 1'b0);
            if ($urandom_range(0, 7) == 0) drive(1'b1, 1'b0, 1'b0, 0, kk, al);
            if (idx == 0) drive(1'b1, 1'b1, 1'b1, pat_val(pat, x, y), kk, al);
            else drive(1'b1, 1'b1, 1'b0, pat_val(pat, x, y),
                       int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic start_test(input bit s, input int sx, input int sy);
        sel = s;
        m_w = s ? 10 : 8;
        m_h = s ? 6 : 4;
        out_count = 0; fd_count = 0; spot_pix = -1; spot_x = sx; spot_y = sy;
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{0, 0, 1'b1, 0, -1, 32, 7, 3, 31};
        vecs[1] = '{0, 1, 1'b0, 1, -1,  8, 2, 1, 24};
        vecs[2] = '{0, 1, 1'b0, 1, -1,  8, 3, 1, 26};
        vecs[3] = '{0, 1, 1'b1, 2, -1,  8, 0, 0, 25};
        vecs[4] = '{0, 1, 1'b1, 3, -1,  8, 3, 1, 255};
        vecs[5] = '{1, 2, 1'b1, 1, -1,  2, 1, 0, 20};
        vecs[6] = '{0, 2, 1'b0, 1, -1,  2, 1, 0, 4};
        vecs[7] = '{0, 1, 1'b1, 0,  8,  8, 1, 1, 22};

        reset = 1'b0; flow_enabled = 1'b0; in_valid = 1'b0; sof = 1'b0;
        pix_in = '0; k = '0; algorithm_select = 1'b0;
        #1;
        check("reset_pix", 32'(a_pix), 0);
        check("reset_x", 32'(a_x), 0);
        check("reset_y", 32'(a_y), 0);
        check("reset_ov", 32'(a_ov), 0);
        check("reset_fd", 32'(a_fd), 0);
        #20 reset = 1'b1;
        idle(2);

        foreach (vecs[i]) begin
            start_test(vecs[i].sel[0], vecs[i].sx, vecs[i].sy);
            run_frame(vecs[i].k, vecs[i].alg, vecs[i].pat, vecs[i].stall_at, m_w * m_h);
            idle(3);
            check("out_count", out_count, vecs[i].exp_count);
            check("frame_done_count", fd_count, 1);
            check("spot_value", spot_pix, vecs[i].spix);
            check("scoreboard_empty", sb.size(), 0);
        end

        // Resync mid-row 2 with k moving from 1 to 2.
        start_test(1'b0, 1, 0);
        run_frame(1, 1'b1, 1, -1, 19);
        run_frame(2, 1'b1, 1, -1, m_w * m_h);
        idle(3);
        check("resync_out_count", out_count, 6);
        check("resync_frame_done", fd_count, 1);
        check("resync_spot", spot_pix, 20);
        check("resync_sb_empty", sb.size(), 0);

        // Asynchronous reset mid-frame, then ignored beats, then a clean frame.
        start_test(1'b0, 3, 1);
        run_frame(1, 1'b1, 1, -1, 13);
        idle(2);
        #1 reset = 1'b0;
        m_active = 1'b0;
        #1;
        check("midreset_pix", 32'(a_pix), 0);
        check("midreset_x", 32'(a_x), 0);
        check("midreset_y", 32'(a_y), 0);
        check("midreset_ov", 32'(a_ov), 0);
        check("midreset_b_pix", 32'(b_pix), 0);
        #1 reset = 1'b1;
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0, 77, 1, 1'b1);
        idle(2);
        out_count = 0; fd_count = 0;
        run_frame(1, 1'b1, 1, -1, m_w * m_h);
        idle(3);
        check("postreset_out_count", out_count, 8);
        check("postreset_frame_done", fd_count, 1);
        check("postreset_spot", spot_pix, 31);
        check("postreset_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
